// File: rtl/exec_alu_mc.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift/carry ops plus an
// iterative shift-add multiply, with a 4-bit condition-code register {C,V,N,Z}.
module exec_alu_mc #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   src,
    input  logic [WIDTH-1:0]   dst,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               ccr_load,
    input  logic [3:0]         ccr_in,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         ccr,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_PASS = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_SETC = 4'hA;
    localparam logic [3:0] OP_CLRC = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     result_r;
    logic [3:0]           ccr_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;

    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic [WIDTH:0]       inc_s;
    logic [WIDTH:0]       dec_s;
    logic [WIDTH:0]       shl_s;
    logic [WIDTH:0]       shr_s;
    logic [2*WIDTH-1:0]   acc_nxt_s;
    logic [3:0]           mul_ccr_s;
    logic [WIDTH-1:0]     res_s;
    logic [3:0]           ccr_s;
    logic                 c_s;
    logic                 v_s;
    logic                 zn_s;

    // Bit WIDTH of the shift-left and bit 0 of the shift-right hold the last bit shifted out.
    assign add_s = {1'b0, dst} + {1'b0, src};
    assign sub_s = {1'b0, dst} - {1'b0, src};
    assign inc_s = {1'b0, src} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s = {1'b0, src} - {{WIDTH{1'b0}}, 1'b1};
    assign shl_s = {1'b0, src} << shamt;
    assign shr_s = {src, 1'b0} >> shamt;

    assign acc_nxt_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    assign mul_ccr_s = {(|acc_nxt_s[2*WIDTH-1:WIDTH]), ccr_r[2],
                        acc_nxt_s[WIDTH-1], (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}})};

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ccr       = ccr_r;
    assign busy      = busy_r;

    // Single-cycle result and next condition codes for the presented opcode.
    always_comb begin
        res_s = dst;
        c_s   = ccr_r[3];
        v_s   = ccr_r[2];
        zn_s  = 1'b0;
        case (op)
            OP_ADD: begin
                res_s = add_s[WIDTH-1:0];
                c_s   = add_s[WIDTH];
                v_s   = (dst[WIDTH-1] == src[WIDTH-1]) && (add_s[WIDTH-1] != dst[WIDTH-1]);
                zn_s  = 1'b1;
            end
            OP_SUB: begin
                res_s = sub_s[WIDTH-1:0];
                c_s   = sub_s[WIDTH];
                v_s   = (dst[WIDTH-1] != src[WIDTH-1]) && (sub_s[WIDTH-1] != dst[WIDTH-1]);
                zn_s  = 1'b1;
            end
            OP_AND: begin
                res_s = dst & src;
                zn_s  = 1'b1;
            end
            OP_OR: begin
                res_s = dst | src;
                zn_s  = 1'b1;
            end
            OP_NOT: begin
                res_s = ~src;
                zn_s  = 1'b1;
            end
            OP_INC: begin
                res_s = inc_s[WIDTH-1:0];
                c_s   = inc_s[WIDTH];
                v_s   = !src[WIDTH-1] && inc_s[WIDTH-1];
                zn_s  = 1'b1;
            end
            OP_DEC: begin
                res_s = dec_s[WIDTH-1:0];
                c_s   = dec_s[WIDTH];
                v_s   = src[WIDTH-1] && !dec_s[WIDTH-1];
                zn_s  = 1'b1;
            end
            OP_SHL: begin
                res_s = shl_s[WIDTH-1:0];
                c_s   = (shamt != {SHAMT_W{1'b0}}) ? shl_s[WIDTH] : ccr_r[3];
                zn_s  = 1'b1;
            end
            OP_SHR: begin
                res_s = shr_s[WIDTH:1];
                c_s   = (shamt != {SHAMT_W{1'b0}}) ? shr_s[0] : ccr_r[3];
                zn_s  = 1'b1;
            end
            OP_SETC: begin
                res_s = dst;
                c_s   = 1'b1;
            end
            OP_CLRC: begin
                res_s = dst;
                c_s   = 1'b0;
            end
            OP_PASS: begin
                res_s = dst;
            end
            default: begin
                res_s = dst;
            end
        endcase
        ccr_s = {c_s, v_s,
                 zn_s ? res_s[WIDTH-1] : ccr_r[1],
                 zn_s ? (res_s == {WIDTH{1'b0}}) : ccr_r[0]};
    end

    // Control FSM, multiply datapath and registered outputs; ccr_load has final say on ccr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            result_r    <= {WIDTH{1'b0}};
            ccr_r       <= 4'b0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            mcand_r     <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mcand_r  <= {{WIDTH{1'b0}}, src};
                            mplier_r <= dst;
                            acc_r    <= {(2*WIDTH){1'b0}};
                            cnt_r    <= {CNT_W{1'b0}};
                            busy_r   <= 1'b1;
                            state_r  <= ST_MUL;
                        end else begin
                            result_r    <= res_s;
                            ccr_r       <= ccr_s;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        result_r    <= acc_nxt_s[WIDTH-1:0];
                        ccr_r       <= mul_ccr_s;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            if (ccr_load) begin
                ccr_r <= ccr_in;
            end
        end
    end

endmodule

// File: tb/tb_exec_alu_mc.sv
// Directed self-checking bench for exec_alu_mc (WIDTH=16); expected values are hand-computed.
module tb_exec_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] src;
    logic [15:0] dst;
    logic [3:0]  shamt;
    logic        ccr_load;
    logic [3:0]  ccr_in;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  ccr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int ov_seen;

    exec_alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src(src), .dst(dst), .shamt(shamt),
        .ccr_load(ccr_load), .ccr_in(ccr_in), .out_valid(out_valid),
        .result(result), .ccr(ccr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] d, input logic [15:0] s,
                         input logic [3:0] sh);
        in_valid = 1'b1;
        op       = o;
        dst      = d;
        src      = s;
        shamt    = sh;
    endtask

    task automatic expect_done(input string tag, input logic [15:0] r, input logic [3:0] c);
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, {16'd0, result}, {16'd0, r});
        chk({tag, "_ccr"}, {28'd0, ccr}, {28'd0, c});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 4'h0;
        src      = 16'h0000;
        dst      = 16'h0000;
        shamt    = 4'h0;
        ccr_load = 1'b0;
        ccr_in   = 4'h0;
        #3;
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_ccr", {28'd0, ccr}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset after a completed ADD
        drive(4'h1, 16'hFFFF, 16'h0002, 4'h0);
        tick();
        expect_done("pre_rst_add", 16'h0001, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_result", {16'd0, result}, 32'd0);
        chk("async_ccr", {28'd0, ccr}, 32'd0);
        chk("async_ov", {31'd0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        chk("async_ready", {31'd0, in_ready}, 32'd1);

        // Overflow then carry, back to back
        drive(4'h1, 16'h7FFF, 16'h0001, 4'h0);
        tick();
        expect_done("add_ovf", 16'h8000, 4'b0110);
        drive(4'h1, 16'hFFFF, 16'h0001, 4'h0);
        tick();
        expect_done("add_carry", 16'h0000, 4'b1001);

        drive(4'h2, 16'h0003, 16'h0005, 4'h0);
        tick();
        expect_done("sub_borrow", 16'hFFFE, 4'b1010);
        drive(4'h3, 16'h0000, 16'hFFFF, 4'h0);
        tick();
        expect_done("and_zero", 16'h0000, 4'b1001);

        drive(4'h8, 16'h0000, 16'h8001, 4'h1);
        tick();
        expect_done("shl1", 16'h0002, 4'b1000);
        drive(4'h9, 16'h0000, 16'h0003, 4'h0);
        tick();
        expect_done("shr0", 16'h0003, 4'b1000);
        drive(4'hB, 16'h1234, 16'h0000, 4'h0);
        tick();
        expect_done("clrc", 16'h1234, 4'b0000);
        drive(4'hA, 16'h5555, 16'h0000, 4'h0);
        tick();
        expect_done("setc", 16'h5555, 4'b1000);
        drive(4'h9, 16'h0000, 16'h0006, 4'h2);
        tick();
        expect_done("shr2", 16'h0001, 4'b1000);
        drive(4'h5, 16'h0000, 16'h00FF, 4'h0);
        tick();
        expect_done("not", 16'hFF00, 4'b1010);
        drive(4'h6, 16'h0000, 16'h7FFF, 4'h0);
        tick();
        expect_done("inc_ovf", 16'h8000, 4'b0110);
        drive(4'h7, 16'h0000, 16'h0000, 4'h0);
        tick();
        expect_done("dec_borrow", 16'hFFFF, 4'b1010);
        drive(4'h4, 16'h0F00, 16'h00F0, 4'h0);
        tick();
        expect_done("or", 16'h0FF0, 4'b1000);
        drive(4'hE, 16'hBEEF, 16'h0000, 4'h0);
        tick();
        expect_done("op_e_pass", 16'hBEEF, 4'b1000);
        in_valid = 1'b0;
        tick();
        chk("idle_ov", {31'd0, out_valid}, 32'd0);
        chk("idle_hold", {16'd0, result}, 32'h0000BEEF);

        // Small multiply, no overflow
        drive(4'hC, 16'h0005, 16'h0003, 4'h0);
        tick();
        chk("mul_a_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        ov_seen = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("mul_a_early", ov_seen, 32'd0);
        tick();
        expect_done("mul_a", 16'h000F, 4'b0000);

        // Multiply with a held ADD that must wait for in_ready
        drive(4'hC, 16'h0100, 16'h0100, 4'h0);
        tick();
        chk("mul_b_ready0", {31'd0, in_ready}, 32'd0);
        chk("mul_b_busy0", {31'd0, busy}, 32'd1);
        chk("mul_b_ov0", {31'd0, out_valid}, 32'd0);
        drive(4'h1, 16'h0001, 16'h0002, 4'h0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("mul_b_stall_ready", {31'd0, in_ready}, 32'd0);
            chk("mul_b_stall_ov", {31'd0, out_valid}, 32'd0);
        end
        tick();
        expect_done("mul_b", 16'h0000, 4'b1001);
        chk("mul_b_ready", {31'd0, in_ready}, 32'd1);
        chk("mul_b_busy", {31'd0, busy}, 32'd0);
        tick();
        expect_done("held_add", 16'h0003, 4'b0000);

        // ccr_load beats a coincident completion
        drive(4'h1, 16'h0010, 16'h0020, 4'h0);
        ccr_load = 1'b1;
        ccr_in   = 4'b0101;
        tick();
        expect_done("ccr_load", 16'h0030, 4'b0101);
        ccr_load = 1'b0;

        // Reset in multiply cycle 8 aborts it
        drive(4'hC, 16'h0005, 16'h0003, 4'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk("mul_c_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("abort_no_ov", ov_seen, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
